// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 memory responder: device register map,
// FSM state encoding and decoded access target.
package lc3_pkg;

  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;
  localparam logic [15:0] DSR_READY = 16'h8000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    WAIT   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    TGT_RAM  = 3'd0,
    TGT_KBSR = 3'd1,
    TGT_KBDR = 3'd2,
    TGT_DSR  = 3'd3,
    TGT_DDR  = 3'd4,
    TGT_NONE = 3'd5
  } target_t;

endpackage

// File: rtl/lc3_ram.sv
// Single-port DEPTH x 16 RAM, synchronous read and write, contents not reset.
module lc3_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/lc3_mem_responder.sv
// LC-3 load/store target: REQ/ACK responder over RAM plus keyboard/display MMIO.
// Device registers are decoded only when LC3_MMIO_EN is defined.
module lc3_mem_responder
  import lc3_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic        WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] WDATA,
  output logic        ACK,
  output logic [15:0] RDATA,
  output logic        ERR,
  input  logic [15:0] SW,
  input  logic        KEY_STB,
  output logic [15:0] LED,
  output state_t      dbg_state
);

  // Handshake: REQ is held until ACK; ACK/ERR/RDATA are valid for exactly the
  // one cycle spent in RESP, and REQ must drop before another request is taken.
  state_t        state, state_nx;
  target_t       tgt_dec, tgt_q;
  logic [AW-1:0] addr_q;
  logic [15:0]   wdata_q, reg_q, ram_q, kbdr, led_r;
  logic          we_q, kb_ready, ram_we;

  always_comb begin
    tgt_dec = TGT_NONE;
    if (ADDR < 16'(DEPTH)) tgt_dec = TGT_RAM;
`ifdef LC3_MMIO_EN
    else begin
      case (ADDR)
        ADDR_KBSR: tgt_dec = TGT_KBSR;
        ADDR_KBDR: tgt_dec = TGT_KBDR;
        ADDR_DSR:  tgt_dec = TGT_DSR;
        ADDR_DDR:  tgt_dec = TGT_DDR;
        default:   tgt_dec = TGT_NONE;
      endcase
    end
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (REQ) state_nx = ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = WAIT;
      WAIT:    if (!REQ) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ACK   = 1'b0;
    ERR   = 1'b0;
    RDATA = 16'h0000;
    if (state == RESP) begin
      ACK   = 1'b1;
      ERR   = (tgt_q == TGT_NONE);
      RDATA = (tgt_q == TGT_RAM) ? ram_q : reg_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q  <= '0;
      wdata_q <= 16'h0000;
      we_q    <= 1'b0;
      tgt_q   <= TGT_NONE;
    end else if (state == IDLE && REQ) begin
      addr_q  <= ADDR[AW-1:0];
      wdata_q <= WDATA;
      we_q    <= WE;
      tgt_q   <= tgt_dec;
    end
  end

  // Register reads are captured on the ACCESS edge so KBDR returns its pre-edge value.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      reg_q <= 16'h0000;
    end else if (state == ACCESS) begin
      case (tgt_q)
        TGT_KBSR: reg_q <= {kb_ready, 15'b0};
        TGT_KBDR: reg_q <= kbdr;
        TGT_DSR:  reg_q <= DSR_READY;
        TGT_DDR:  reg_q <= led_r;
        default:  reg_q <= 16'h0000;
      endcase
    end
  end

  assign ram_we = (state == ACCESS) && we_q && (tgt_q == TGT_RAM);

  lc3_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (CLK),
    .we    (ram_we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (ram_q)
  );

`ifdef LC3_MMIO_EN
  // A key strobe outranks the clear caused by a same-cycle KBDR read.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      kbdr     <= 16'h0000;
      kb_ready <= 1'b0;
      led_r    <= 16'h0000;
    end else begin
      if (KEY_STB) begin
        kbdr     <= SW;
        kb_ready <= 1'b1;
      end else if (state == ACCESS && !we_q && tgt_q == TGT_KBDR) begin
        kb_ready <= 1'b0;
      end
      if (state == ACCESS && we_q && tgt_q == TGT_DDR) led_r <= wdata_q;
    end
  end
`else
  logic unused_io;
  assign unused_io = ^{SW, KEY_STB};
  assign kbdr      = 16'h0000;
  assign kb_ready  = 1'b0;
  assign led_r     = 16'h0000;
`endif

  assign LED       = led_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed self-checking bench for lc3_mem_responder; expectations follow
// whether LC3_MMIO_EN is defined for the build.
module tb_lc3_mem_responder;
  import lc3_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ = 1'b0;
  logic        WE = 1'b0;
  logic [15:0] ADDR = 16'h0;
  logic [15:0] WDATA = 16'h0;
  logic        ACK;
  logic [15:0] RDATA;
  logic        ERR;
  logic [15:0] SW = 16'h0;
  logic        KEY_STB = 1'b0;
  logic [15:0] LED;
  state_t      dbg_state;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

`ifdef LC3_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  lc3_mem_responder #(.DEPTH(1024)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
    .ACK(ACK), .RDATA(RDATA), .ERR(ERR), .SW(SW), .KEY_STB(KEY_STB),
    .LED(LED), .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transaction; optionally strobes KEY_STB with stb_sw during ACCESS.
  task automatic do_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input bit stb_mid, input logic [15:0] stb_sw,
                        output logic [15:0] rd, output logic err, output int lat);
    bit got = 0;
    rd  = 16'h0;
    err = 1'b0;
    lat = 0;
    @(negedge CLK);
    REQ = 1'b1; WE = we; ADDR = addr; WDATA = wdata;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
      KEY_STB = 1'b0;
      if (stb_mid && lat == 1) begin
        SW = stb_sw;
        KEY_STB = 1'b1;
      end
      if (ACK) begin
        got = 1;
        rd  = RDATA;
        err = ERR;
      end
    end
    KEY_STB = 1'b0;
    if (!got) check("ack_timeout", 16'd0, 16'd1);
    REQ = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("ack_one_cycle", {15'b0, ACK}, 16'd0);
    @(posedge CLK);
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] addr,
                        input logic [15:0] exp_d, input logic exp_e);
    logic [15:0] rd;
    logic        e;
    int          lat;
    do_txn(1'b0, addr, 16'h0, 0, 16'h0, rd, e, lat);
    check({tag, "_data"}, rd, exp_d);
    check({tag, "_err"}, {15'b0, e}, {15'b0, exp_e});
    check({tag, "_lat"}, 16'(lat), 16'd2);
  endtask

  task automatic wr_chk(input string tag, input logic [15:0] addr,
                        input logic [15:0] data, input logic exp_e);
    logic [15:0] rd;
    logic        e;
    int          lat;
    do_txn(1'b1, addr, data, 0, 16'h0, rd, e, lat);
    check({tag, "_err"}, {15'b0, e}, {15'b0, exp_e});
    check({tag, "_lat"}, 16'(lat), 16'd2);
  endtask

  task automatic key_pulse(input logic [15:0] v);
    @(negedge CLK);
    SW = v;
    KEY_STB = 1'b1;
    @(negedge CLK);
    KEY_STB = 1'b0;
  endtask

  logic [15:0] sweep_addr [4] = '{16'h0000, 16'h0001, 16'h03FF, 16'h0200};
  logic [15:0] sweep_data [4] = '{16'hA5A5, 16'h0F0F, 16'hFFFF, 16'h8001};

  initial begin
    logic [15:0] rd;
    logic        e;
    int          lat;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_ack", {15'b0, ACK}, 16'd0);
    check("rst_rdata", RDATA, 16'h0000);
    check("rst_err", {15'b0, ERR}, 16'd0);
    check("rst_led", LED, 16'h0000);
    check("rst_state", 16'(dbg_state), 16'(IDLE));
    RST = 1'b0;

    wr_chk("wr5", 16'h0005, 16'h1234, 1'b0);
    rd_chk("rd5", 16'h0005, 16'h1234, 1'b0);

    foreach (sweep_addr[i]) begin
      wr_chk("sweep_wr", sweep_addr[i], sweep_data[i], 1'b0);
      exp_q.push_back(sweep_data[i]);
    end
    foreach (sweep_addr[i]) rd_chk("sweep_rd", sweep_addr[i], exp_q.pop_front(), 1'b0);

    rd_chk("rd_400", 16'h0400, 16'h0000, 1'b1);
    rd_chk("rd_ffff", 16'hFFFF, 16'h0000, 1'b1);
    wr_chk("wr_400", 16'h0400, 16'hDEAD, 1'b1);
    rd_chk("rd0_after_400", 16'h0000, 16'hA5A5, 1'b0);

    key_pulse(16'hBEEF);
    rd_chk("kbsr1", ADDR_KBSR, MMIO ? 16'h8000 : 16'h0000, !MMIO);
    rd_chk("kbdr1", ADDR_KBDR, MMIO ? 16'hBEEF : 16'h0000, !MMIO);
    rd_chk("kbsr2", ADDR_KBSR, 16'h0000, !MMIO);

    do_txn(1'b0, ADDR_KBDR, 16'h0, 1, 16'h0042, rd, e, lat);
    check("kbdr_race_data", rd, MMIO ? 16'hBEEF : 16'h0000);
    check("kbdr_race_lat", 16'(lat), 16'd2);
    rd_chk("kbsr3", ADDR_KBSR, MMIO ? 16'h8000 : 16'h0000, !MMIO);
    rd_chk("kbdr3", ADDR_KBDR, MMIO ? 16'h0042 : 16'h0000, !MMIO);

    wr_chk("ddr_wr", ADDR_DDR, 16'h00FF, !MMIO);
    check("led", LED, MMIO ? 16'h00FF : 16'h0000);
    rd_chk("ddr_rd", ADDR_DDR, MMIO ? 16'h00FF : 16'h0000, !MMIO);
    rd_chk("dsr_rd", ADDR_DSR, MMIO ? 16'h8000 : 16'h0000, !MMIO);
    wr_chk("dsr_wr", ADDR_DSR, 16'h1111, !MMIO);
    rd_chk("fe08_rd", 16'hFE08, 16'h0000, 1'b1);

    wr_chk("wr10", 16'h0010, 16'h5555, 1'b0);
    @(negedge CLK);
    REQ = 1'b1; WE = 1'b1; ADDR = 16'h0010; WDATA = 16'hAAAA;
    @(posedge CLK);
    @(negedge CLK);
    check("pre_rst_state", 16'(dbg_state), 16'(ACCESS));
    RST = 1'b1;
    #1;
    check("mid_rst_state", 16'(dbg_state), 16'(IDLE));
    REQ = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("mid_rst_ack", {15'b0, ACK}, 16'd0);
    end
    check("mid_rst_led", LED, 16'h0000);
    RST = 1'b0;
    rd_chk("rd10_after_rst", 16'h0010, 16'h5555, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lc3_mem_responder.md
# lc3_mem_responder

Memory-side responder for the LC-3 core's load/store port, the target end of the core's address/data/write-enable interface. Accepts one request at a time over a REQ/ACK handshake and returns read data or commits write data. Backs the low address space with a synchronous-read RAM and decodes the LC-3 memory-mapped device registers for switch input and LED output. Sits between the core and the board I/O in the top level.

## Interface
- DEPTH, 1024: RAM words; power of two; valid range 16..32768.
- AW, $clog2(DEPTH): RAM index width.
- CLK  in  1  system clock; all logic on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- REQ  in  1  request valid; held by the initiator until ACK.
- WE  in  1  1 = write, 0 = read; sampled with REQ.
- ADDR  in  16  word address.
- WDATA  in  16  write data.
- ACK  out  1  one-cycle completion pulse.
- RDATA  out  16  read data; valid only while ACK = 1.
- ERR  out  1  one-cycle pulse with ACK when the address is unmapped.
- SW  in  16  switch value, captured as keyboard data.
- KEY_STB  in  1  one-cycle pulse from an already-debounced button.
- LED  out  16  display data register.

## Operation
- Reset values: ACK = 0, RDATA = 0, ERR = 0, LED = 0, KBSR.ready = 0, KBDR = 0, FSM = IDLE. RAM contents are not reset.
- FSM states and transitions:
  - IDLE: on REQ, latch ADDR, WE, and WDATA, decode the target, and go to ACCESS.
  - ACCESS: issue the RAM read or write, or the register access. Go to RESP.
  - RESP: drive ACK = 1 with RDATA and ERR, then go to WAIT.
  - WAIT: stay while REQ = 1. Return to IDLE when REQ = 0. A new request therefore requires REQ to drop for at least one cycle.
- Address decode:
  - ADDR < DEPTH selects RAM at index ADDR[AW-1:0].
  - 0xFE00 is KBSR: bit 15 = ready, other bits read 0, writes ignored.
  - 0xFE02 is KBDR: read returns the captured value and clears KBSR.ready; writes ignored.
  - 0xFE04 is DSR: reads 0x8000, writes ignored.
  - 0xFE06 is DDR: a write loads LED; a read returns LED.
  - Any other address reads 0, ignores writes, and raises ERR with ACK.
- KEY_STB captures SW into KBDR and sets KBSR.ready in the same cycle. This happens in any FSM state.
- If KEY_STB and a KBDR-read clear occur in the same cycle, the set wins: ready = 1 and the new SW value is kept. The read returns the value captured before that edge.
- If KEY_STB arrives while ready = 1, KBDR is overwritten. There is no overrun flag.
- No arithmetic on data. Only the address compare ADDR < DEPTH, done as an unsigned 16-bit compare.

## Timing
- Latency from the REQ sample edge in IDLE to ACK high is exactly 2 cycles for reads and writes, RAM and registers alike.
- A RAM write commits on the ACCESS edge. A read in the same transaction order sees the new data.
- Throughput is at most one transaction per 4 cycles.
- RAM read is synchronous with 1-cycle latency, absorbed by ACCESS.
- REQ dropping before ACK is a protocol violation. The FSM completes the transaction anyway, then returns through WAIT.
- RST asserted mid-transaction aborts immediately:
  - ACK and ERR go to 0.
  - A RAM write not yet at its ACCESS edge is dropped.

## Configuration
- LC3_MMIO_EN defined:
  - Device registers at 0xFE00–0xFE06 are decoded as described.
  - SW, KEY_STB, and LED are functional.
- LC3_MMIO_EN undefined:
  - No register decode; every address ≥ DEPTH reads 0 with ERR.
  - SW and KEY_STB are ignored, and LED is held at 0.
  - Ports remain present.

## Structure
- The shared package lc3_pkg holds:
  - Constants ADDR_KBSR, ADDR_KBDR, ADDR_DSR, ADDR_DDR.
  - DSR_READY = 16'h8000.
  - The FSM state enum typedef (IDLE, ACCESS, RESP, WAIT).
- Sub-module lc3_ram: single-port, synchronous read and write, DEPTH×16, no reset. Instantiated once.

## Test plan
- Write 0x1234 to 0x0005, then read 0x0005 → RDATA = 0x1234, ACK 2 cycles after REQ, ERR = 0.
- Read 0x0400 with DEPTH = 1024 → RDATA = 0x0000, ERR = 1 with ACK; RAM unchanged.
- SW = 0xBEEF plus KEY_STB, then read KBSR → 0x8000. Read KBDR → 0xBEEF. Read KBSR again → 0x0000.
- KEY_STB with SW = 0x0042 on the same edge as a KBDR read's ACCESS → the read returns the old value, then KBSR reads 0x8000 and KBDR reads 0x0042.
- Write 0x00FF to 0xFE06 → LED = 0x00FF from the ACCESS edge. Read DSR → 0x8000. With LC3_MMIO_EN undefined, LED stays 0 and ERR = 1.
- Assert RST during ACCESS of a write of 0xAAAA to 0x0010 → ACK never pulses, FSM is in IDLE, and address 0x0010 keeps its previous value.
